spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter RD_WAIT, default 2: cycles between the last MOSI frame bit and the first MISO sample in a read-data frame (range 1..15).
REQ-002 Parameter GAP_CYC, default 2: minimum cycles SS_n is held high between frames (range 1..15).
REQ-003 clk  input  1  single system clock; all outputs registered on its rising edge; the SPI slave shares this clock.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  request pulse; accepted only when busy=0.
REQ-006 cmd  input  2  frame command: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-007 tx_data  input  8  address or data byte sent with cmd.
REQ-008 busy  output  1  high from the cycle after acceptance through the end of the inter-frame gap.
REQ-009 done  output  1  one-cycle pulse in the cycle SS_n returns high.
REQ-010 rx_data  output  8  byte captured from MISO in a read-data frame.
REQ-011 rx_valid  output  1  one-cycle pulse, coincident with done, only for completed cmd=11 frames.
REQ-012 err  output  1  one-cycle pulse when a start is refused (see Configuration).
REQ-013 SS_n  output  1  active-low slave select.
REQ-014 MOSI  output  1  serial data to slave, MSB first.
REQ-015 MISO  input  1  serial data from slave, MSB first.

Function
REQ-016 States: IDLE, SEL, SHIFT_OUT, WAIT_RD, SHIFT_IN, GAP; the state register is cleared to IDLE on reset.
REQ-017 IDLE: SS_n=1, MOSI=0; a start sampled at edge T latches {cmd,tx_data} into a 10-bit frame register and moves to SEL.
REQ-018 SEL (cycle T+1): SS_n=0 and MOSI=cmd[1], giving the slave its CHK_CMD read/write select bit; busy=1.
REQ-019 SHIFT_OUT (cycles T+2..T+11): MOSI drives frame bits 9 down to 0, one bit per cycle, for exactly 10 cycles.
REQ-020 After SHIFT_OUT, cmd 00/01/10: SS_n=1 at T+12, done pulses at T+12, and the machine enters GAP.
REQ-021 After SHIFT_OUT, cmd 11: WAIT_RD holds SS_n=0 and MOSI=0 for RD_WAIT cycles.
REQ-022 SHIFT_IN then follows for 8 cycles, holding SS_n=0 and MOSI=0, and shifts MISO into the receive register MSB first on each rising edge.
REQ-023 At the end of SHIFT_IN, in the same cycle: SS_n=1, rx_data is loaded, done and rx_valid pulse, and the machine enters GAP.
REQ-024 GAP: SS_n=1, busy=1 for GAP_CYC cycles, then IDLE with busy=0.
REQ-025 A start while busy=1 is ignored and leaves no pending request; in that case err is not asserted.
REQ-026 rx_data holds its value until the next completed read-data frame; frames other than cmd 11 leave it unchanged.
REQ-027 tx_data and cmd changes after acceptance do not affect the frame in flight.

Reset
REQ-028 When rst_n=0 at a rising edge: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, err=0, rx_data=8'h00, and the frame, receive, and counter registers are cleared.
REQ-029 Reset mid-frame aborts the frame without a done pulse; SS_n is high in the first cycle after the reset edge.

Configuration
REQ-030 With macro SPI_MASTER_RD_ORDER_CHK_EN defined, a start with cmd=11 is refused unless the most recent completed frame since reset was cmd=10.
REQ-031 A refused start (with SPI_MASTER_RD_ORDER_CHK_EN defined) pulses err for one cycle, leaves SS_n high and busy low, and keeps the machine in IDLE.
REQ-032 Without SPI_MASTER_RD_ORDER_CHK_EN, every accepted command is sent, err is tied to 0, and no order-tracking logic exists.

Verification
REQ-033 start, cmd=00, tx_data=8'hFF at T -> SS_n low T+1..T+11, MOSI sequence 0,0,0,1,1,1,1,1,1,1,1, done at T+12, rx_valid=0.
REQ-034 cmd=01, tx_data=8'h55 -> MOSI sequence 0,0,1,0,1,0,1,0,1,0,1; attached slave RAM holds 8'h55 at address 8'hFF.
REQ-035 cmd=10, tx_data=8'hFF, then cmd=11 with a slave returning 8'hA5 -> SS_n low for 11+RD_WAIT+8 cycles, rx_data=8'hA5, rx_valid and done coincide.
REQ-036 start re-asserted every cycle during a frame -> exactly one frame, with at least GAP_CYC SS_n-high cycles before the next.
REQ-037 rst_n=0 at T+6 of a write frame -> SS_n=1 at T+7, no done pulse, and a subsequent frame completes normally.
REQ-038 SPI_MASTER_RD_ORDER_CHK_EN defined, cmd=11 right after reset -> err pulse, SS_n stays high; then a 10 frame followed by an 11 frame are both accepted.

Source files
------------

// File: rtl/spi_master_if.sv
// SPI master bus bundle: the request/response handshake plus the three SPI wires.
// The master modport is the controller's view. The slave modport is the view of
// whoever drives requests and MISO.
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       err;
  logic       ss_n;
  logic       mosi;
  logic       miso;

  modport master (
    input  start, cmd, tx_data, miso,
    output busy, done, rx_data, rx_valid, err, ss_n, mosi
  );

  modport slave (
    output start, cmd, tx_data, miso,
    input  busy, done, rx_data, rx_valid, err, ss_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI master for a slave that shares clk. A frame is one read/write select bit
// followed by {cmd, tx_data} sent MSB first. A read-data frame then waits
// RD_WAIT cycles and shifts in one byte from MISO.
// Optional feature macro: SPI_MASTER_RD_ORDER_CHK_EN. When it is defined, a
// read-data start is refused unless the last completed frame was a read-address.
//
// state     | meaning
// IDLE      | SS_n high, waiting for start
// SEL       | SS_n low, MOSI = cmd[1] (slave read/write select)
// SHIFT_OUT | frame bits 9..0 on MOSI, one per cycle
// WAIT_RD   | read-data turnaround, RD_WAIT cycles
// SHIFT_IN  | 8 MISO bits captured MSB first
// GAP       | SS_n high for GAP_CYC cycles, busy still high
module spi_master #(
  parameter int RD_WAIT = 2,
  parameter int GAP_CYC = 2
) (
  input logic           clk,
  input logic           rst_n,
  spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SEL, SHIFT_OUT, WAIT_RD, SHIFT_IN, GAP} state_t;

  localparam logic [3:0] RD_WAIT_LD = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LD     = 4'(GAP_CYC - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [9:0] frame;
  logic [7:0] rx_shift;
  logic [7:0] rx_data_q;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       accept;

`ifdef SPI_MASTER_RD_ORDER_CHK_EN
  logic refuse;
  logic rd_ok;
  logic err_q;
`endif

  // Next-state, down-counter and next-output decode; outputs are registered from these.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    accept     = 1'b0;
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
    refuse     = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
`ifdef SPI_MASTER_RD_ORDER_CHK_EN
          if (bus.cmd == 2'b11 && !rd_ok) refuse = 1'b1;
          else                            accept = 1'b1;
`else
          accept = 1'b1;
`endif
        end
        if (accept) begin
          state_d = SEL;
          ss_n_d  = 1'b0;
          mosi_d  = bus.cmd[1];
          busy_d  = 1'b1;
        end
      end
      SEL: begin
        state_d = SHIFT_OUT;
        cnt_d   = 4'd9;
        ss_n_d  = 1'b0;
        mosi_d  = frame[9];
      end
      SHIFT_OUT: begin
        if (cnt == 4'd0) begin
          if (frame[9:8] == 2'b11) begin
            state_d = WAIT_RD;
            cnt_d   = RD_WAIT_LD;
            ss_n_d  = 1'b0;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LD;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt - 4'd1;
          ss_n_d = 1'b0;
          mosi_d = frame[cnt - 4'd1];
        end
      end
      WAIT_RD: begin
        ss_n_d = 1'b0;
        if (cnt == 4'd0) begin
          state_d = SHIFT_IN;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      SHIFT_IN: begin
        if (cnt == 4'd0) begin
          state_d    = GAP;
          cnt_d      = GAP_LD;
          done_d     = 1'b1;
          rx_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt - 4'd1;
          ss_n_d = 1'b0;
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered SPI/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Frame capture at acceptance, so later cmd/tx_data changes cannot touch the frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)      frame <= '0;
    else if (accept) frame <= {bus.cmd, bus.tx_data};
  end

  // MISO shift register; the byte is published on the last SHIFT_IN edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift  <= '0;
      rx_data_q <= '0;
    end else if (state == SHIFT_IN) begin
      rx_shift <= {rx_shift[6:0], bus.miso};
      if (rx_valid_d) rx_data_q <= {rx_shift[6:0], bus.miso};
    end
  end

`ifdef SPI_MASTER_RD_ORDER_CHK_EN
  // Remember whether the last completed frame was a read-address, and flag refused starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= refuse;
      if (done_d) rd_ok <= (frame[9:8] == 2'b10);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ss_n     = ss_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule
